// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared state encoding and parameter helpers for layer_seq.
package layer_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        PROJ = 2'd2,
        DONE = 2'd3
    } state_t;

    // Accumulator width: full product plus growth for N products and the bias.
    function automatic int unsigned acc_width(input int unsigned width, input int unsigned n);
        return 2 * width + $clog2(n + 1);
    endfunction

    // Width of an index counter over 'count' items, at least one bit.
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    // MSB position of chunk 'idx' in a flat vector of 'count' chunks,
    // chunk 0 being the most significant.
    function automatic int unsigned slice_msb(input int unsigned idx,
                                              input int unsigned count,
                                              input int unsigned width);
        return (count - idx) * width - 1;
    endfunction

endpackage

// File: rtl/layer_seq_sat_project.sv
// sat_project: signed saturation from IW to OW bits, optional ReLU.
// Optional feature macro: SEQ_RELU_EN (clamp negative results to zero).
module sat_project #(
    parameter int IW = 34,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] i_val,
    output logic signed [OW-1:0] o_val
);

    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [OW-1:0] w_sat;

    // Clamp to the representable OW-bit signed range.
    always_comb begin
        if (i_val > MAXV) begin
            w_sat = MAXV[OW-1:0];
        end else if (i_val < MINV) begin
            w_sat = MINV[OW-1:0];
        end else begin
            w_sat = i_val[OW-1:0];
        end
    end

`ifdef SEQ_RELU_EN
    // ReLU applied after saturation.
    always_comb o_val = w_sat[OW-1] ? '0 : w_sat;
`else
    // Saturated value passed through unchanged.
    always_comb o_val = w_sat;
`endif

endmodule

// File: rtl/layer_seq.sv
// layer_seq: time-multiplexed fully connected layer, one MAC per cycle.
// Optional feature macro: SEQ_RELU_EN (ReLU after saturation, same latency).
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int M     = 4,
    parameter logic [WIDTH*N*M-1:0] WEIGHTS_FLAT = '0,
    parameter logic [WIDTH*M-1:0]   BIASES_FLAT  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [N-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out [M-1:0],
    output logic                    busy
);

    localparam int ACCW = acc_width(WIDTH, N);
    localparam int JW   = idx_width(N);
    localparam int KW   = idx_width(M);

    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [JW-1:0] J_ONE  = JW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    state_t r_state;
    state_t w_state_next;

    logic signed [WIDTH-1:0]   r_in_lat [N-1:0];
    logic signed [WIDTH-1:0]   r_out    [M-1:0];
    logic        [JW-1:0]      r_j;
    logic        [KW-1:0]      r_k;
    logic signed [ACCW-1:0]    r_acc;

    logic signed [WIDTH-1:0]   w_weight [M-1:0][N-1:0];
    logic signed [WIDTH-1:0]   w_bias   [M-1:0];
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [WIDTH-1:0]   w_sat;
    logic signed [WIDTH-1:0]   w_bias_next;
    logic        [KW-1:0]      w_k_inc;
    logic                      w_j_last;
    logic                      w_k_last;

    for (genvar gk = 0; gk < M; gk++) begin : g_neuron
        assign w_bias[gk] = BIASES_FLAT[slice_msb(gk, M, WIDTH) -: WIDTH];
        for (genvar gj = 0; gj < N; gj++) begin : g_input
            assign w_weight[gk][gj] = WEIGHTS_FLAT[slice_msb(gk*N + gj, M*N, WIDTH) -: WIDTH];
        end
    end

    assign w_j_last = (r_j == J_LAST);
    assign w_k_last = (r_k == K_LAST);
    assign w_k_inc  = r_k + K_ONE;

    // Single signed multiplier and the bias to preload for the next neuron.
    always_comb begin
        w_prod      = (2*WIDTH)'(r_in_lat[r_j]) * (2*WIDTH)'(w_weight[r_k][r_j]);
        w_bias_next = w_k_last ? '0 : w_bias[w_k_inc];
    end

    sat_project #(
        .IW (ACCW),
        .OW (WIDTH)
    ) u_sat (
        .i_val (r_acc),
        .o_val (w_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/status outputs from the state register.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = MAC;
                end
            end
            MAC: begin
                if (w_j_last) begin
                    w_state_next = PROJ;
                end
            end
            PROJ: begin
                w_state_next = w_k_last ? DONE : MAC;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: input latch, accumulator, indices and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_j   <= '0;
            r_k   <= '0;
            for (int unsigned i = 0; i < M; i++) begin
                r_out[i] <= '0;
            end
            for (int unsigned i = 0; i < N; i++) begin
                r_in_lat[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            r_in_lat[i] <= in[i];
                        end
                        r_j   <= '0;
                        r_k   <= '0;
                        r_acc <= ACCW'(w_bias[0]);
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACCW'(w_prod);
                    if (!w_j_last) begin
                        r_j <= r_j + J_ONE;
                    end
                end
                PROJ: begin
                    r_out[r_k] <= w_sat;
                    r_acc      <= ACCW'(w_bias_next);
                    r_j        <= '0;
                    if (!w_k_last) begin
                        r_k <= w_k_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output vector straight from the output registers.
    always_comb out = r_out;

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: scoreboard bench for layer_seq (WIDTH=16, N=2, M=2).
// Honours SEQ_RELU_EN in its expected values.
module tb_layer_seq;

    localparam int W = 16;
    localparam int N = 2;
    localparam int M = 2;

    // n0={2,3}, n1={-1,1}; saturation variant n0={32767,32767}; biases {10,-5}.
    localparam logic [W*N*M-1:0] WA = 64'h0002_0003_FFFF_0001;
    localparam logic [W*N*M-1:0] WB = 64'h7FFF_7FFF_FFFF_0001;
    localparam logic [W*M-1:0]   BS = 32'h000A_FFFB;

    typedef struct {
        int lat;
        int o0;
        int o1;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] iv  = '0;
    logic [1:0] ir;
    logic [1:0] ov;
    logic [1:0] ord = '0;
    logic [1:0] bz;
    logic [1:0] ov_d = '0;

    logic signed [W-1:0] din  [2][2];
    logic signed [W-1:0] dout [2][2];
    logic signed [W-1:0] a_in [1:0];
    logic signed [W-1:0] b_in [1:0];
    logic signed [W-1:0] a_out [1:0];
    logic signed [W-1:0] b_out [1:0];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        a_in[0]    = din[0][0];
        a_in[1]    = din[0][1];
        b_in[0]    = din[1][0];
        b_in[1]    = din[1][1];
        dout[0][0] = a_out[0];
        dout[0][1] = a_out[1];
        dout[1][0] = b_out[0];
        dout[1][1] = b_out[1];
    end

    layer_seq #(.WIDTH(W), .N(N), .M(M), .WEIGHTS_FLAT(WA), .BIASES_FLAT(BS)) u_a (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in(a_in),
        .out_valid(ov[0]), .out_ready(ord[0]), .out(a_out), .busy(bz[0])
    );

    layer_seq #(.WIDTH(W), .N(N), .M(M), .WEIGHTS_FLAT(WB), .BIASES_FLAT(BS)) u_b (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in(b_in),
        .out_valid(ov[1]), .out_ready(ord[1]), .out(b_out), .busy(bz[1])
    );

    function automatic int rl(input int v);
`ifdef SEQ_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: got no event, expected one", nm);
    endtask

    // Monitor: latency on out_valid rise, output values on each output handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            int sz;
            sz = (d == 0) ? qa.size() : qb.size();
            if (ov[d] && !ov_d[d]) begin
                if (sz == 0) begin
                    fail($sformatf("unexpected_out_valid_d%0d", d));
                end else begin
                    if (d == 0) e = qa[0];
                    else e = qb[0];
                    check($sformatf("latency_d%0d", d), cyc, e.lat);
                end
            end
            if (ov[d] && ord[d]) begin
                if (sz == 0) begin
                    fail($sformatf("unexpected_output_d%0d", d));
                end else begin
                    if (d == 0) e = qa.pop_front();
                    else e = qb.pop_front();
                    check($sformatf("out0_d%0d", d), int'(dout[d][0]), e.o0);
                    check($sformatf("out1_d%0d", d), int'(dout[d][1]), e.o1);
                end
            end
        end
        ov_d = ov;
    end

    // Present a vector, wait (bounded) for its acceptance, queue its expectation.
    task automatic send(input int d, input int x0, input int x1, input int e0, input int e1,
                        input bit keep, output int hs);
        exp_t e;
        int waited;
        waited = 0;
        hs = -1;
        din[d][0] = 16'(x0);
        din[d][1] = 16'(x1);
        iv[d] = 1'b1;
        while (hs < 0 && waited < 50) begin
            @(negedge clk);
            if (ir[d] && !rst) begin
                hs = cyc;
                e.lat = cyc + 7;
                e.o0 = e0;
                e.o1 = e1;
                if (d == 0) qa.push_back(e);
                else qb.push_back(e);
            end
            waited++;
        end
        if (hs < 0) fail("handshake_timeout");
        @(posedge clk);
        #1;
        if (!keep) iv[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? qa.size() : qb.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? qa.size() : qb.size()) != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs, h1, h2, n;
        din[0][0] = 16'sd4;
        din[0][1] = 16'sd5;
        din[1][0] = '0;
        din[1][1] = '0;

        // Reset held with in_valid asserted: nothing accepted, reset values.
        iv[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", int'(ir[0]), 1);
            check("rst_out_valid", int'(ov[0]), 0);
            check("rst_busy", int'(bz[0]), 0);
            check("rst_out0", int'(dout[0][0]), 0);
            check("rst_out1", int'(dout[0][1]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        check("post_rst_busy", int'(bz[0]), 0);
        @(posedge clk);
        #1;

        // Basic.
        ord = 2'b11;
        send(0, 4, 5, 33, rl(-4), 1'b0, hs);
        drain(0);

        // Backpressure: output held for 5 cycles, then released.
        ord[0] = 1'b0;
        send(0, 1, 1, 15, rl(-5), 1'b0, hs);
        n = 0;
        while (!ov[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ov[0]) fail("bp_out_valid_timeout");
        repeat (5) begin
            @(negedge clk);
            check("bp_out0", int'(dout[0][0]), 15);
            check("bp_out1", int'(dout[0][1]), rl(-5));
            check("bp_in_ready", int'(ir[0]), 0);
            check("bp_busy", int'(bz[0]), 1);
            check("bp_out_valid", int'(ov[0]), 1);
        end
        @(posedge clk);
        #1;
        ord[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", int'(ir[0]), 1);
        check("bp_release_busy", int'(bz[0]), 0);
        check("bp_release_out_valid", int'(ov[0]), 0);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high.
        send(0, 1, 1, 15, rl(-5), 1'b1, h1);
        send(0, -2, 0, 6, rl(-3), 1'b0, h2);
        check("b2b_interval", h2 - h1, 8);
        drain(0);

        // Reset in the third MAC cycle.
        send(0, 4, 5, 33, rl(-4), 1'b0, hs);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_busy", int'(bz[0]), 1);
        check("mid_in_ready", int'(ir[0]), 0);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(ir[0]), 1);
        check("midrst_out_valid", int'(ov[0]), 0);
        check("midrst_busy", int'(bz[0]), 0);
        check("midrst_out0", int'(dout[0][0]), 0);
        check("midrst_out1", int'(dout[0][1]), 0);
        @(posedge clk);
        #1;
        send(0, 4, 5, 33, rl(-4), 1'b0, hs);
        drain(0);

        // Saturation on the reconfigured instance.
        send(1, 32767, 32767, 32767, rl(-5), 1'b0, hs);
        drain(1);
        send(1, -32767, -32767, rl(-32768), rl(-5), 1'b0, hs);
        drain(1);

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_seq.md
# layer_seq

Time-multiplexed sequencer for one fully connected layer. It accepts an N-element input vector and computes M neuron outputs using a single multiply-accumulate datapath, one product per cycle. Each output is the saturated dot product plus bias. The block sits between upstream and downstream layer stages with valid/ready handshakes, and replaces M parallel combinational neurons where area matters more than throughput.

## Interface
- WIDTH, 16: bit width of inputs, weights, biases and outputs (signed).
- N, 4: inputs per neuron.
- M, 4: neurons (outputs) in the layer.
- WEIGHTS_FLAT, all zero: [WIDTH*N*M-1:0]. The weight for neuron k, input j is the slice `[(M*N-(k*N+j))*WIDTH-1 -: WIDTH]`, most significant chunk first; always interpreted signed.
- BIASES_FLAT, all zero: [WIDTH*M-1:0]. The bias for neuron k is the slice `[(M-k)*WIDTH-1 -: WIDTH]`, signed.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the input vector is valid.
- in_ready  out  1  the block can accept a vector.
- in  in  signed [WIDTH-1:0] x N (unpacked [N-1:0])  input vector.
- out_valid  out  1  the output vector is valid.
- out_ready  in  1  downstream accepts the output.
- out  out  signed [WIDTH-1:0] x M (unpacked [M-1:0])  output vector.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE → MAC on in_valid && in_ready.
  - MAC → PROJ after input index j = N-1.
  - PROJ → MAC for the next neuron, or → DONE after neuron k = M-1.
  - DONE → IDLE on out_valid && out_ready.
- IDLE: in_ready=1.
  - On handshake, latch the whole input vector.
  - Clear j and k.
  - Load the accumulator with BIAS[0], sign-extended.
- MAC: accumulate acc += in_latched[j] * W[k][j]; then j++.
- PROJ:
  - Saturate acc to WIDTH bits and write it to out_reg[k].
  - Reload acc with BIAS[k+1] and reset j to 0.
  - Increment k.
- DONE: out_valid=1. out holds stable until the handshake completes.
- Arithmetic:
  - Each product is 2*WIDTH bits.
  - The accumulator is ACCW = 2*WIDTH + $clog2(N+1) bits, so it never overflows.
  - Projection saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. There is no wraparound anywhere.
- in_ready=0 in MAC, PROJ and DONE. A new vector is accepted only in IDLE, so in_valid asserted during DONE waits.
- rst in any state:
  - Next state is IDLE.
  - out_valid=0, in_ready=1 on the following cycle.
  - out_reg, acc, j and k are all cleared.
  - Any in-flight computation is discarded.
- Reset values: in_ready=1, out_valid=0, busy=0, out all zeros.
- With N=1 the block still spends one MAC cycle and one PROJ cycle per neuron.

## Timing
- Input handshake at cycle t.
- Neuron k spends MAC cycles t+1+k(N+1) … t+k(N+1)+N, then PROJ at t+(k+1)(N+1).
- out_valid rises at t+M(N+1)+1.
- After the output handshake at cycle u: state is IDLE at u+1, with in_ready=1 at u+1.
- Minimum period per vector is M(N+1)+2 cycles.
- All outputs are registered. There are no combinational paths from in_valid or out_ready to any output.

## Configuration
- SEQ_RELU_EN defined: PROJ writes max(0, saturated value), i.e. ReLU after saturation.
- SEQ_RELU_EN undefined: the saturated value is written unchanged. Latency is identical in both builds.

## Structure
- Package layer_seq_pkg holds:
  - the state enum (IDLE, MAC, PROJ, DONE);
  - a function for accumulator width;
  - a function extracting weight and bias slices from the flat parameters.
- Sub-module sat_project: combinational saturation from IW to OW bits, plus optional ReLU under SEQ_RELU_EN. It is instantiated once, on the PROJ path.
- The multiplier is inline; there is one instance only.

## Test plan
All scenarios use WIDTH=16, N=2, M=2, weights n0={2,3}, n1={-1,1}, biases {10,-5}.

- Basic: in={4,5} at t → out_valid at t+7, out={33,-4} (with SEQ_RELU_EN: {33,0}).
- Saturation:
  - Reconfigure n0 weights to {32767,32767} and apply in={32767,32767} → out[0]=32767.
  - Negate the inputs → out[0]=-32768.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out stable, in_ready=0, busy=1; then release → IDLE next cycle.
- Back-to-back: in_valid held high with out_ready=1 → vectors accepted every 8 cycles, with correct outputs for in={1,1}→{15,-5} and in={-2,0}→{6,-3}.
- Reset mid-operation: assert rst in the 3rd MAC cycle → next cycle in_ready=1, out_valid=0, out={0,0}; then a new vector in={4,5} yields {33,-4}.
- Reset values: hold rst for 3 cycles with in_valid=1 → no vector is accepted and all outputs are at their reset values.
